// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the period meter and the clock-divider blocks.
package clk_period_meter_pkg;

  localparam int unsigned ClkHz = 100000000;
  localparam int unsigned DefaultCntW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMeasHigh,
    StMeasLow
  } state_e;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Two-flop synchronizer plus history flop; produces synchronized level and one-cycle edge strobes.
module clk_period_meter_sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with a one-cycle result strobe and a loss-of-signal timeout.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ  = ClkHz,
  parameter int unsigned CNT_W   = DefaultCntW,
  parameter int unsigned TIMEOUT = 2 * CLK_HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             timeout_out
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic sig_level_unused;
  logic rise, fall;

  clk_period_meter_sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (sig_level_unused),
    .rise  (rise),
    .fall  (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rise) begin
          state_d = StMeasHigh;
          cnt_d   = One;
        end
      end
      StMeasHigh: begin
        cnt_d = cnt_q + One;
        // A rise here means a missed fall; restart the measurement silently.
        if (rise) begin
          cnt_d = One;
        end else if (fall) begin
          state_d    = StMeasLow;
          high_lat_d = cnt_q;
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      StMeasLow: begin
        cnt_d = cnt_q + One;
        // Edge takes priority over a coincident timeout.
        if (rise) begin
          state_d   = StMeasHigh;
          cnt_d     = One;
          period_d  = cnt_q;
          high_d    = high_lat_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign meas_valid  = valid_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: sig_in is driven on falling edges, outputs sampled there.
module tb_clk_period_meter;

  localparam int unsigned CntW = 32;
  localparam int unsigned Tmo  = 5000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sig_in = 1'b0;
  logic [CntW-1:0] period_out, high_out;
  logic            meas_valid, timeout_out;

  clk_period_meter #(
    .CNT_W   (CntW),
    .TIMEOUT (Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .meas_valid  (meas_valid),
    .timeout_out (timeout_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int            vq[$];
  logic [31:0]   pq[$];
  logic [31:0]   hq[$];
  int            to_rise, to_fall;
  logic          prev_to;
  int            b1, b2, b4, b6, b7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    vq.delete();
    pq.delete();
    hq.delete();
    to_rise = -1;
    to_fall = -1;
    prev_to = timeout_out;
  endtask

  // Sample outputs at this falling edge, then drive the new sig_in level.
  task automatic step(input logic lvl);
    @(negedge clk);
    if (meas_valid === 1'b1) begin
      vq.push_back(cyc);
      pq.push_back(period_out);
      hq.push_back(high_out);
    end
    if (timeout_out === 1'b1 && prev_to === 1'b0) to_rise = cyc;
    if (timeout_out === 1'b0 && prev_to === 1'b1) to_fall = cyc;
    prev_to = timeout_out;
    sig_in = lvl;
  endtask

  task automatic train(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) step(lvl);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_timeout", timeout_out, 0);
    rst = 1'b0;
    clear_log();
    hold(1'b0, 5);

    // 1: period 1000, high 300, five periods
    b1 = cyc + 1;
    train(300, 700, 5);
    check("s1_nvalid", vq.size(), 4);
    for (int i = 0; i < vq.size(); i++) begin
      check("s1_vcyc", vq[i], b1 + 1000 * (i + 1) + 3);
      check("s1_period", pq[i], 1000);
      check("s1_high", hq[i], 300);
    end
    check("s1_no_timeout", to_rise, -1);

    // 2: loss of signal
    clear_log();
    hold(1'b0, 6000);
    check("s2_to_cyc", to_rise, b1 + 4000 + 3 + Tmo);
    check("s2_nvalid", vq.size(), 0);
    check("s2_period_held", period_out, 1000);
    check("s2_high_held", high_out, 300);
    check("s2_timeout", timeout_out, 1);

    // 3: resume with period 400, high 200
    clear_log();
    b2 = cyc + 1;
    train(200, 200, 2);
    check("s3_nvalid", vq.size(), 1);
    if (vq.size() > 0) begin
      check("s3_vcyc", vq[0], b2 + 403);
      check("s3_period", pq[0], 400);
      check("s3_high", hq[0], 200);
    end
    check("s3_to_fall", to_fall, b2 + 403);

    // 4: minimum waveform; the first rise closes the 400-cycle period from step 3
    clear_log();
    b4 = cyc + 1;
    train(2, 2, 6);
    hold(1'b0, 4);
    check("s4_nvalid", vq.size(), 6);
    if (vq.size() == 6) begin
      check("s4_p0", pq[0], 400);
      check("s4_h0", hq[0], 200);
      for (int k = 1; k < 6; k++) begin
        check("s4_vcyc", vq[k], b4 + 4 * k + 3);
        check("s4_period", pq[k], 4);
        check("s4_high", hq[k], 2);
      end
    end
    check("s4_timeout", timeout_out, 0);

    // 5: asynchronous reset in the middle of a high phase
    hold(1'b1, 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_rst_period", period_out, 0);
    check("s5_rst_high", high_out, 0);
    check("s5_rst_valid", meas_valid, 0);
    check("s5_rst_timeout", timeout_out, 0);
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    clear_log();
    hold(1'b0, 5);
    check("s5_post_period", period_out, 0);
    check("s5_post_timeout", timeout_out, 0);
    b6 = cyc + 1;
    train(50, 50, 3);
    hold(1'b0, 10);
    check("s5_nvalid", vq.size(), 2);
    if (vq.size() == 2) begin
      check("s5_vcyc0", vq[0], b6 + 103);
      check("s5_vcyc1", vq[1], b6 + 203);
      check("s5_period", pq[1], 100);
      check("s5_high", hq[1], 50);
    end

    // 6: stuck high after one rise (which also closes a 110-cycle period)
    clear_log();
    b7 = cyc + 1;
    hold(1'b1, 5100);
    check("s6_nvalid", vq.size(), 1);
    if (vq.size() == 1) check("s6_period", pq[0], 110);
    check("s6_to_cyc", to_rise, b7 + 3 + Tmo);
    check("s6_timeout", timeout_out, 1);
    check("s6_high_held", high_out, 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
